// File: rtl/multdiv_unit.sv
// multdiv_unit: 33-edge signed Booth multiplier / restoring divider; start pulses in, result + exception + one-cycle RDY out
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d, m_q, m_d, res_q, res_d;
  logic             qm1_q, qm1_d, neg_q, neg_d, div_exc_q, div_exc_d;
  logic             exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic             start, last;
  logic [WIDTH-1:0] a_abs, b_abs, mul_lo, div_lo;
  logic [WIDTH:0]   m_ext, booth_sum, mul_hi, shifted, diff, div_hi;
  assign start     = ctrl_MULT | ctrl_DIV;
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign a_abs     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign m_ext     = {m_q[WIDTH-1], m_q};
  assign booth_sum = (lo_q[0] & ~qm1_q) ? hi_q - m_ext :
                     (~lo_q[0] & qm1_q) ? hi_q + m_ext : hi_q;
  assign mul_hi    = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign mul_lo    = {booth_sum[0], lo_q[WIDTH-1:1]};
  assign shifted   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, m_q};
  assign div_hi    = diff[WIDTH] ? shifted : diff;
  assign div_lo    = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      neg_q     <= 1'b0;
      div_exc_q <= 1'b0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      neg_q     <= neg_d;
      div_exc_q <= div_exc_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) state_d = MUL_RUN;
    else if (ctrl_DIV) state_d = DIV_RUN;
    else if (state_q == DONE) state_d = IDLE;
    else if (state_q != IDLE && last) state_d = DONE;
  end
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    neg_d     = neg_q;
    div_exc_d = div_exc_q;
    res_d     = res_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;
    if (start) begin
      cnt_d     = '0;
      hi_d      = '0;
      qm1_d     = 1'b0;
      busy_d    = 1'b1;
      lo_d      = ctrl_MULT ? data_operandB : a_abs;
      m_d       = ctrl_MULT ? data_operandA : b_abs;
      neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_exc_d = (data_operandB == '0) |
                  (data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB);
    end else if (state_q == MUL_RUN) begin
      hi_d  = mul_hi;
      lo_d  = mul_lo;
      qm1_d = lo_q[0];
      cnt_d = cnt_q + CW'(1);
      res_d = last ? mul_lo : res_q;
      exc_d = last ? mul_hi[WIDTH-1:0] != {WIDTH{mul_lo[WIDTH-1]}} : exc_q;
    end else if (state_q == DIV_RUN) begin
      hi_d  = div_hi;
      lo_d  = div_lo;
      cnt_d = cnt_q + CW'(1);
      res_d = !last ? res_q : (m_q == '0) ? '0 : neg_q ? -div_lo : div_lo;
      exc_d = last ? div_exc_q : exc_q;
    end else if (state_q == DONE) begin
      rdy_d  = 1'b1;
      busy_d = 1'b0;
    end
  end
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit
module tb_multdiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1, ctrl_mult = 1'b0, ctrl_div = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY, busy;
  typedef struct packed {logic [31:0] res; logic exc;} exp_t;
  typedef struct {logic mul; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic exc;} vec_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clk), .reset(reset), .data_operandA(op_a), .data_operandB(op_b),
    .ctrl_MULT(ctrl_mult), .ctrl_DIV(ctrl_div), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
  );
  function automatic exp_t model(input logic mul, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] q;
    if (mul) begin
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return '{p[31:0], p[63:32] != {32{p[31]}}};
    end
    if (b == 32'd0) return '{32'd0, 1'b1};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '{32'h8000_0000, 1'b1};
    q = $signed(a) / $signed(b);
    return '{q, 1'b0};
  endfunction
  task automatic issue(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(negedge clk);
    ctrl_mult = mul; ctrl_div = div; op_a = a; op_b = b;
    sb.push_back(e);
    @(negedge clk);
    ctrl_mult = 1'b0; ctrl_div = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask
  task automatic wait_rdy(output int n, output int bb);
    n = 0; bb = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!data_resultRDY && !busy) bb++;
    end while (!data_resultRDY && n < 40);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (data_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b exp 0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
  endtask
  task automatic test_directed;
    vec_t v[9] = '{
      '{1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
      '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0},
      '{1'b0, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0},
      '{1'b0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0},
      '{1'b0, 32'd3,          32'd5,         32'd0,         1'b0},
      '{1'b0, 32'd5,          32'd0,         32'd0,         1'b1},
      '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
      '{1'b1, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1}
    };
    int n, bb;
    exp_t e;
    foreach (v[i]) begin
      issue(v[i].mul, !v[i].mul, v[i].a, v[i].b, '{v[i].res, v[i].exc});
      wait_rdy(n, bb);
      e = sb.pop_front();
      checks++; if (n !== 33) begin errors++; $display("FAIL dir%0d_latency got %0d exp 33", i, n); end
      checks++; if (bb !== 0 || busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy early_drops %0d busy_at_rdy %b", i, bb, busy); end
      checks++; if (data_result !== e.res) begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, data_result, e.res); end
      checks++; if (data_exception !== e.exc) begin errors++; $display("FAIL dir%0d_exc got %b exp %b", i, data_exception, e.exc); end
      @(posedge clk); #1;
      checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL dir%0d_rdy_pulse got %b exp 0", i, data_resultRDY); end
      checks++; if (data_result !== e.res) begin errors++; $display("FAIL dir%0d_hold got %h exp %h", i, data_result, e.res); end
    end
  endtask
  task automatic test_restart;
    int n, bb;
    exp_t e;
    issue(1'b0, 1'b1, 32'd9, 32'd3, '{32'd3, 1'b0});
    repeat (8) @(negedge clk);
    void'(sb.pop_front());
    issue(1'b1, 1'b0, 32'd6, 32'd6, '{32'd36, 1'b0});
    wait_rdy(n, bb);
    e = sb.pop_front();
    checks++; if (n !== 33) begin errors++; $display("FAIL restart_latency got %0d exp 33", n); end
    checks++; if (data_result !== e.res) begin errors++; $display("FAIL restart_result got %h exp %h", data_result, e.res); end
    issue(1'b1, 1'b1, 32'd8, 32'd2, '{32'd16, 1'b0});
    wait_rdy(n, bb);
    e = sb.pop_front();
    checks++; if (n !== 33) begin errors++; $display("FAIL prio_latency got %0d exp 33", n); end
    checks++; if (data_result !== e.res) begin errors++; $display("FAIL prio_result got %h exp %h", data_result, e.res); end
  endtask
  task automatic test_reset_mid;
    int n, bb, rdys;
    exp_t e;
    issue(1'b1, 1'b0, 32'h1234_5678, 32'd3, model(1'b1, 32'h1234_5678, 32'd3));
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    checks++; if (data_result !== 32'd0 || data_exception !== 1'b0) begin errors++; $display("FAIL midreset_out got %h/%b exp 0/0", data_result, data_exception); end
    checks++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin errors++; $display("FAIL midreset_ctl busy %b rdy %b exp 0/0", busy, data_resultRDY); end
    rdys = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (data_resultRDY) rdys++; end
    checks++; if (rdys !== 0) begin errors++; $display("FAIL midreset_no_rdy got %0d exp 0", rdys); end
    issue(1'b1, 1'b0, 32'd2, 32'd3, '{32'd6, 1'b0});
    wait_rdy(n, bb);
    e = sb.pop_front();
    checks++; if (n !== 33) begin errors++; $display("FAIL postreset_latency got %0d exp 33", n); end
    checks++; if (data_result !== e.res) begin errors++; $display("FAIL postreset_result got %h exp %h", data_result, e.res); end
  endtask
  task automatic test_back_to_back;
    int n, bb;
    logic mul;
    logic [31:0] a, b;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      mul = 1'($urandom_range(0, 1));
      a = (i % 3 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      b = (i % 2 == 0) ? 32'($signed(8'($urandom))) : $urandom;
      issue(mul, !mul, a, b, model(mul, a, b));
      wait_rdy(n, bb);
      e = sb.pop_front();
      checks++; if (n !== 33) begin errors++; $display("FAIL b2b%0d_latency got %0d exp 33", i, n); end
      checks++; if (data_result !== e.res || data_exception !== e.exc) begin errors++; $display("FAIL b2b%0d mul=%b a=%h b=%h got %h/%b exp %h/%b", i, mul, a, b, data_result, data_exception, e.res, e.exc); end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiplier/divider that sits directly downstream of the processor's execute stage.
- The processor issues a one-cycle start pulse with operands, stalls its PC while busy, then consumes the result on a ready strobe.
- Results are written back to the regfile via the normal write port; r30/rstatus is written on exception.
- Runs on the processor clock domain.

Parameters:
- WIDTH, 32, operand/result width; the processor instantiates with 32; only 32 is verified.

Ports:
- clock  input  1  processor clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
- data_operandB  input  WIDTH  multiplier / divisor (two's complement)
- ctrl_MULT  input  1  start-multiply pulse; operands sampled on same edge
- ctrl_DIV  input  1  start-divide pulse; operands sampled on same edge
- data_result  output  WIDTH  product low word / quotient
- data_exception  output  1  overflow or divide-by-zero flag for the completed op
- data_resultRDY  output  1  one-cycle completion strobe
- busy  output  1  high from start edge until the result edge; processor stall source

Behaviour:
- Reset: on any edge with reset=1, go to IDLE.
  - Clear data_result=0, data_exception=0, data_resultRDY=0, busy=0, iteration counter=0.
  - Reset overrides start pulses and aborts any op in flight; no RDY is ever produced for an aborted op.
- States: IDLE -> MUL_RUN | DIV_RUN -> DONE -> IDLE.
- Start (edge E0), from any state other than reset:
  - ctrl_MULT=1 enters MUL_RUN; ctrl_DIV=1 (with ctrl_MULT=0) enters DIV_RUN.
  - Operands are latched, counter=0, busy=1.
  - ctrl_MULT and ctrl_DIV both high: MULT wins.
  - A start while running or in DONE aborts the current op and restarts with the new operands; the old op produces no RDY.
- Iterations: one per edge, E1..E32 (32 iterations).
  - At E32 the state is DONE; result and exception are registered.
  - At E33: data_resultRDY=1 for exactly one cycle (E33..E34), busy=0 from E33, state returns to IDLE.
  - Fixed latency: RDY rises 33 edges after the start edge, for every op including exceptions.
- data_result and data_exception hold their values after RDY until the next completion or reset. Intermediate values never appear on the outputs.
- MULT:
  - Radix-2 Booth, 64-bit signed product; data_result = product[31:0].
  - data_exception=1 iff product[63:32] is not the sign extension of product[31].
- DIV:
  - Signed, truncation toward zero: magnitude restoring division, then sign fix.
  - Quotient sign = signA XOR signB; remainder discarded.
  - Divisor 0: data_result=0, data_exception=1.
  - 0x80000000 / -1: data_result=0x80000000, data_exception=1.
  - All other cases: data_exception=0.
- Operands may change after E0 without affecting the result.
- ctrl_MULT/ctrl_DIV held high for several cycles restarts the op on each edge; the processor guarantees single-cycle pulses.

Test Plan:
- Multiply: reset 2 cycles; pulse ctrl_MULT with A=7, B=-3 (0xFFFFFFFD) -> busy high E0..E32; at E33 RDY=1 for one cycle, result=0xFFFFFFEB, exception=0; RDY=0 at E34, result held.
- Multiply overflow: A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Also A=0x7FFFFFFF, B=1 -> result=0x7FFFFFFF, exception=0.
- Divide: A=-100, B=7 -> result=0xFFFFFFF2 (-14), exception=0. A=100, B=-7 -> result=-14. A=3, B=5 -> result=0.
- Divide exceptions: A=5, B=0 -> result=0, exception=1 with RDY at E33. A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Restart and priority:
  - ctrl_DIV (A=9, B=3) then ctrl_MULT at E10 with A=6, B=6 -> no RDY at E33 of the first op; RDY at E10+33 with result=36.
  - ctrl_MULT and ctrl_DIV together with A=8, B=2 -> result=16.
- Reset mid-op: start MULT, assert reset at E15 for 1 cycle -> all outputs 0, busy=0; no RDY for 40 cycles. A new MULT 2*3 afterwards yields 6 after 33 edges.
